config_reporter: RTL and testbench

Serial transmitter that reads back the active configuration set. On a request pulse it snapshots the five 16-bit limits (four temperature, one humidity) and sends them on a UART line. It uses the same frame format, byte order and baud rate that `config_manager` accepts on `rx_serial`, so a host or a second board can verify or mirror the settings. It sits beside `config_manager` and is driven directly from its `*_out` buses.

---
 rtl/config_pkg.sv | 47 ++++
 rtl/uart_tx_byte.sv | 154 +++++++++++++++
 rtl/config_reporter.sv | 183 ++++++++++++++++++
 tb/tb_config_reporter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/config_pkg.sv
// config_pkg
//
// Shared definitions for the configuration read-back path: default bit
// timing, the number of 16-bit words in a configuration set, the state
// encodings of the main sequencer and of the byte transmitter, and the
// odd-parity helper that config_manager also uses on its receive side.
//
// Optional feature macro: CONFIG_REPORTER_CHECKSUM_EN
//   defined   -> an extra checksum frame follows the ten data frames
//   undefined -> exactly ten data frames are sent
package config_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 434;
    localparam int NUM_PALAVRAS         = 5;
    localparam int NUM_BYTES            = 2 * NUM_PALAVRAS;

`ifdef CONFIG_REPORTER_CHECKSUM_EN
    localparam int TOTAL_QUADROS = NUM_BYTES + 1;
`else
    localparam int TOTAL_QUADROS = NUM_BYTES;
`endif

    // Main sequencer states; the numeric values are visible on db_estado.
    typedef enum logic [3:0] {
        INICIAL   = 4'd0,
        CARREGA   = 4'd1,
        TRANSMITE = 4'd2,
        PROXIMO   = 4'd3,
        FIM       = 4'd4
    } estado_t;

    // Byte transmitter states, one per section of the serial frame.
    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        INICIO   = 3'd1,
        DADOS    = 3'd2,
        PARIDADE = 3'd3,
        PARADA   = 3'd4,
        ESPACO   = 3'd5
    } estado_tx_t;

    // Odd parity: data plus the returned bit always holds an odd number of ones.
    function automatic logic paridade_impar(input logic [7:0] dado);
        return ~^dado;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte
//
// Sends one byte as an 11-bit UART frame (start 0, 8 data bits LSB first,
// odd parity, stop 1) followed by GAP_BITS idle bit-times with the line high.
// Every bit lasts exactly CLKS_PER_BIT clocks.
//
// Ports:
//   clock     in   system clock
//   reset     in   asynchronous, active-low reset
//   partida   in   start request, only looked at while idle
//   dado      in   byte to send, captured together with partida
//   tx_serial out  UART line, idle high, registered
//   pronto    out  one-clock pulse in the last clock of the trailing gap
//
// Parameters: CLKS_PER_BIT (at most 512, tick counter is 9 bits),
//             GAP_BITS (0..8).
import config_pkg::*;

module uart_tx_byte #(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int GAP_BITS     = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       partida,
    input  logic [7:0] dado,
    output logic       tx_serial,
    output logic       pronto
);

    localparam logic [8:0] TICK_MAX = 9'(CLKS_PER_BIT - 1);
    localparam logic [2:0] GAP_MAX  = 3'(GAP_BITS - 1);

    estado_tx_t estado, estado_prox;
    logic [8:0] contador_tick, tick_prox;
    logic [2:0] indice_bit, indice_prox;
    logic [7:0] dado_reg, dado_prox;
    logic       paridade_reg, paridade_prox;
    logic       tx_prox;
    logic       fim_bit;

    assign fim_bit = (contador_tick == TICK_MAX);

    // All transmitter state is registered, including the line itself so the
    // UART output never glitches; reset forces the line high at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado        <= OCIOSO;
            contador_tick <= '0;
            indice_bit    <= '0;
            dado_reg      <= '0;
            paridade_reg  <= 1'b0;
            tx_serial     <= 1'b1;
        end else begin
            estado        <= estado_prox;
            contador_tick <= tick_prox;
            indice_bit    <= indice_prox;
            dado_reg      <= dado_prox;
            paridade_reg  <= paridade_prox;
            tx_serial     <= tx_prox;
        end
    end

    // Next-state logic. The line value is computed for the state being
    // entered, so it changes on the same edge as the state. Data bits are
    // taken from a right-shifting copy of the byte, which is why parity is
    // computed at capture time rather than at the end.
    always_comb begin
        estado_prox   = estado;
        tick_prox     = contador_tick + 9'd1;
        indice_prox   = indice_bit;
        dado_prox     = dado_reg;
        paridade_prox = paridade_reg;
        tx_prox       = tx_serial;
        pronto        = 1'b0;

        case (estado)
            OCIOSO: begin
                tick_prox   = '0;
                indice_prox = '0;
                tx_prox     = 1'b1;
                if (partida) begin
                    estado_prox   = INICIO;
                    dado_prox     = dado;
                    paridade_prox = paridade_impar(dado);
                    tx_prox       = 1'b0;
                end
            end

            INICIO: begin
                if (fim_bit) begin
                    tick_prox   = '0;
                    indice_prox = '0;
                    estado_prox = DADOS;
                    tx_prox     = dado_reg[0];
                end
            end

            DADOS: begin
                if (fim_bit) begin
                    tick_prox = '0;
                    if (indice_bit == 3'd7) begin
                        estado_prox = PARIDADE;
                        tx_prox     = paridade_reg;
                    end else begin
                        indice_prox = indice_bit + 3'd1;
                        dado_prox   = {1'b0, dado_reg[7:1]};
                        tx_prox     = dado_reg[1];
                    end
                end
            end

            PARIDADE: begin
                if (fim_bit) begin
                    tick_prox   = '0;
                    estado_prox = PARADA;
                    tx_prox     = 1'b1;
                end
            end

            PARADA: begin
                if (fim_bit) begin
                    tick_prox   = '0;
                    indice_prox = '0;
                    if (GAP_BITS == 0) begin
                        estado_prox = OCIOSO;
                        pronto      = 1'b1;
                    end else begin
                        estado_prox = ESPACO;
                    end
                end
            end

            ESPACO: begin
                if (fim_bit) begin
                    tick_prox = '0;
                    if (indice_bit == GAP_MAX) begin
                        estado_prox = OCIOSO;
                        pronto      = 1'b1;
                    end else begin
                        indice_prox = indice_bit + 3'd1;
                    end
                end
            end

            default: begin
                estado_prox = OCIOSO;
                tick_prox   = '0;
                tx_prox     = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/config_reporter.sv
// config_reporter
//
// Reads back the active configuration set over UART. A request pulse
// snapshots the four temperature limits and the humidity limit, then sends
// them as low byte / high byte pairs in the order temp_lim1..temp_lim4,
// umidade_lim, using the frame format config_manager accepts on rx_serial.
//
// Ports:
//   clock           in   system clock (50 MHz)
//   reset           in   asynchronous, active-low reset
//   enviar_config   in   start request, one clock high
//   temp_lim1_in..temp_lim4_in, umidade_lim_in   in   16-bit limits
//   tx_serial       out  UART line, idle high
//   ocupado         out  high from request acceptance until pronto_envio
//   pronto_envio    out  one-clock pulse after the last frame and its gap
//   db_estado       out  main FSM state for debug
//
// Optional feature macro: CONFIG_REPORTER_CHECKSUM_EN appends an 11th frame
// carrying the XOR of the ten data bytes.
import config_pkg::*;

module config_reporter #(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int GAP_BITS     = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enviar_config,
    input  logic [15:0] temp_lim1_in,
    input  logic [15:0] temp_lim2_in,
    input  logic [15:0] temp_lim3_in,
    input  logic [15:0] temp_lim4_in,
    input  logic [15:0] umidade_lim_in,
    output logic        tx_serial,
    output logic        ocupado,
    output logic        pronto_envio,
    output logic [3:0]  db_estado
);

    localparam logic [3:0] TOTAL_QUADROS_4 = 4'(TOTAL_QUADROS);

    estado_t                      estado, estado_prox;
    logic [16*NUM_PALAVRAS-1:0]   registrador;
    logic [3:0]                   contador_bytes;
    logic [3:0]                   contador_incr;
    logic [7:0]                   dado_tx;
    logic                         partida;
    logic                         pronto_tx;

    assign contador_incr = contador_bytes + 4'd1;

    // Main state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= INICIAL;
        end else begin
            estado <= estado_prox;
        end
    end

    // Sequencing and status outputs. partida is simply held for the whole
    // of TRANSMITE: the transmitter only samples it while idle, and the only
    // idle cycle it sees in TRANSMITE is the first one, so each visit starts
    // exactly one frame.
    always_comb begin
        estado_prox  = estado;
        partida      = 1'b0;
        ocupado      = 1'b0;
        pronto_envio = 1'b0;

        case (estado)
            INICIAL: begin
                if (enviar_config) begin
                    estado_prox = CARREGA;
                end
            end

            CARREGA: begin
                ocupado     = 1'b1;
                estado_prox = TRANSMITE;
            end

            TRANSMITE: begin
                ocupado = 1'b1;
                partida = 1'b1;
                if (pronto_tx) begin
                    estado_prox = PROXIMO;
                end
            end

            PROXIMO: begin
                ocupado = 1'b1;
                if (contador_incr < TOTAL_QUADROS_4) begin
                    estado_prox = TRANSMITE;
                end else begin
                    estado_prox = FIM;
                end
            end

            FIM: begin
                pronto_envio = 1'b1;
                estado_prox  = INICIAL;
            end

            default: begin
                estado_prox = INICIAL;
            end
        endcase
    end

    assign db_estado = 4'(estado);

`ifdef CONFIG_REPORTER_CHECKSUM_EN
    logic [7:0] checksum;

    // Snapshot and byte stepping, plus a running XOR of every byte that has
    // left the shift register. By the time the checksum frame is due the
    // shift register is empty, so the extra XOR of zero afterwards is harmless.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            registrador    <= '0;
            contador_bytes <= '0;
            checksum       <= '0;
        end else begin
            case (estado)
                CARREGA: begin
                    registrador    <= {umidade_lim_in, temp_lim4_in, temp_lim3_in,
                                       temp_lim2_in, temp_lim1_in};
                    contador_bytes <= '0;
                    checksum       <= '0;
                end
                PROXIMO: begin
                    registrador    <= registrador >> 8;
                    contador_bytes <= contador_incr;
                    checksum       <= checksum ^ registrador[7:0];
                end
                default: begin
                end
            endcase
        end
    end

    assign dado_tx = (contador_bytes == 4'(NUM_BYTES)) ? checksum : registrador[7:0];
`else
    // Snapshot and byte stepping. The snapshot is taken once in CARREGA, so
    // later input changes never reach the frames already scheduled.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            registrador    <= '0;
            contador_bytes <= '0;
        end else begin
            case (estado)
                CARREGA: begin
                    registrador    <= {umidade_lim_in, temp_lim4_in, temp_lim3_in,
                                       temp_lim2_in, temp_lim1_in};
                    contador_bytes <= '0;
                end
                PROXIMO: begin
                    registrador    <= registrador >> 8;
                    contador_bytes <= contador_incr;
                end
                default: begin
                end
            endcase
        end
    end

    assign dado_tx = registrador[7:0];
`endif

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .GAP_BITS     (GAP_BITS)
    ) u_tx (
        .clock     (clock),
        .reset     (reset),
        .partida   (partida),
        .dado      (dado_tx),
        .tx_serial (tx_serial),
        .pronto    (pronto_tx)
    );

endmodule

// File: tb/tb_config_reporter.sv
// tb_config_reporter
//
// Drives config_reporter with directed and random configuration sets and
// decodes the UART line by mid-bit sampling. Expected bytes, parity bits,
// frame start times and completion time are derived from the frame rules
// with plain arithmetic. A shorter bit time keeps the run short; all timing
// expectations are expressed in terms of it.
`timescale 1ns/1ps

module tb_config_reporter;

    localparam int CPB        = 40;
    localparam int GAP        = 1;
    localparam int FRAME_CLKS = (11 + GAP) * CPB;
`ifdef CONFIG_REPORTER_CHECKSUM_EN
    localparam int N_FRAMES = 11;
`else
    localparam int N_FRAMES = 10;
`endif
    localparam int DONE_LIMIT = N_FRAMES * (FRAME_CLKS + 2) + 100;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enviar_config = 1'b0;
    logic [15:0] temp_lim1_in = '0;
    logic [15:0] temp_lim2_in = '0;
    logic [15:0] temp_lim3_in = '0;
    logic [15:0] temp_lim4_in = '0;
    logic [15:0] umidade_lim_in = '0;
    logic        tx_serial;
    logic        ocupado;
    logic        pronto_envio;
    logic [3:0]  db_estado;

    config_reporter #(
        .CLKS_PER_BIT (CPB),
        .GAP_BITS     (GAP)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .enviar_config  (enviar_config),
        .temp_lim1_in   (temp_lim1_in),
        .temp_lim2_in   (temp_lim2_in),
        .temp_lim3_in   (temp_lim3_in),
        .temp_lim4_in   (temp_lim4_in),
        .umidade_lim_in (umidade_lim_in),
        .tx_serial      (tx_serial),
        .ocupado        (ocupado),
        .pronto_envio   (pronto_envio),
        .db_estado      (db_estado)
    );

    always #10 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc = cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stp;
        logic       strt;
        int         start_cyc;
    } frame_t;

    frame_t     frames [$];
    logic [7:0] exp_bytes [$];
    int         pronto_cnt = 0;
    int         vectors = 0;
    int         miscompares = 0;

    always @(negedge clock) if (pronto_envio) pronto_cnt = pronto_cnt + 1;

    // Line decoder: a low level while idle is a start bit; each bit is then
    // sampled in the middle of its bit-time.
    initial begin : monitor
        frame_t      f;
        logic [10:0] bits;
        forever begin
            @(negedge clock);
            if (reset && tx_serial == 1'b0) begin
                f.start_cyc = cyc;
                repeat (CPB / 2) @(negedge clock);
                for (int k = 0; k < 11; k++) begin
                    bits[k] = tx_serial;
                    if (k < 10) repeat (CPB) @(negedge clock);
                end
                f.strt = bits[0];
                f.data = bits[8:1];
                f.par  = bits[9];
                f.stp  = bits[10];
                frames.push_back(f);
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors = vectors + 1;
        if (got !== exp) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference: low byte then high byte of each word in order, optional XOR.
    task automatic buildModel(input logic [15:0] w [5]);
        logic [7:0] cks;
        cks = 8'h00;
        exp_bytes.delete();
        for (int i = 0; i < 5; i++) begin
            exp_bytes.push_back(8'(w[i] % 256));
            exp_bytes.push_back(8'(w[i] / 256));
        end
        foreach (exp_bytes[i]) cks = cks ^ exp_bytes[i];
`ifdef CONFIG_REPORTER_CHECKSUM_EN
        exp_bytes.push_back(cks);
`endif
    endtask

    task automatic applyStimulus(input logic [15:0] w [5], output int req_cyc);
        @(negedge clock);
        temp_lim1_in   = w[0];
        temp_lim2_in   = w[1];
        temp_lim3_in   = w[2];
        temp_lim4_in   = w[3];
        umidade_lim_in = w[4];
        enviar_config  = 1'b1;
        req_cyc        = cyc + 1;
        @(negedge clock);
        enviar_config  = 1'b0;
        checkOutput("ocupado_after_request", 32'(ocupado), 32'd1);
        checkOutput("estado_after_request", 32'(db_estado), 32'd1);
    endtask

    task automatic waitDone(output int done_cyc);
        int n;
        n = 0;
        done_cyc = -1;
        while (n < DONE_LIMIT && done_cyc < 0) begin
            @(negedge clock);
            n++;
            if (pronto_envio) done_cyc = cyc;
        end
        if (done_cyc < 0) begin
            checkOutput("pronto_timeout", 32'd0, 32'd1);
        end else begin
            checkOutput("ocupado_at_pronto", 32'(ocupado), 32'd0);
        end
    endtask

    task automatic waitFrames(input int count);
        int n;
        n = 0;
        while (frames.size() < count && n < DONE_LIMIT) begin
            @(negedge clock);
            n++;
        end
        if (frames.size() < count) checkOutput("frame_timeout", 32'(frames.size()), 32'(count));
    endtask

    task automatic checkRun(input int req_cyc, input int done_cyc);
        checkOutput("frame_count", 32'(frames.size()), 32'(exp_bytes.size()));
        for (int i = 0; i < frames.size() && i < exp_bytes.size(); i++) begin
            checkOutput($sformatf("data[%0d]", i), 32'(frames[i].data), 32'(exp_bytes[i]));
            checkOutput($sformatf("parity[%0d]", i), 32'(frames[i].par),
                        (($countones(exp_bytes[i]) % 2) == 0) ? 32'd1 : 32'd0);
            checkOutput($sformatf("start[%0d]", i), 32'(frames[i].strt), 32'd0);
            checkOutput($sformatf("stop[%0d]", i), 32'(frames[i].stp), 32'd1);
            checkOutput($sformatf("start_time[%0d]", i), 32'(frames[i].start_cyc - req_cyc),
                        32'(2 + i * (FRAME_CLKS + 2)));
        end
        checkOutput("pronto_time", 32'(done_cyc - req_cyc),
                    32'(N_FRAMES * FRAME_CLKS + (N_FRAMES - 1) * 2 + 3));
        frames.delete();
    endtask

    initial begin : main
        logic [15:0] words [5];
        int req;
        int done;
        int cnt0;

        // Reset state
        repeat (3) @(negedge clock);
        checkOutput("reset_tx_serial", 32'(tx_serial), 32'd1);
        checkOutput("reset_ocupado", 32'(ocupado), 32'd0);
        checkOutput("reset_pronto", 32'(pronto_envio), 32'd0);
        checkOutput("reset_estado", 32'(db_estado), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Directed run, with a change of inputs and a second request mid-way
        words = '{16'h1000, 16'h2001, 16'h3002, 16'h4003, 16'h5004};
        buildModel(words);
        cnt0 = pronto_cnt;
        applyStimulus(words, req);
        waitFrames(1);
        @(negedge clock);
        temp_lim1_in   = 16'hFFFF;
        temp_lim2_in   = 16'hFFFF;
        temp_lim3_in   = 16'hFFFF;
        temp_lim4_in   = 16'hFFFF;
        umidade_lim_in = 16'hFFFF;
        enviar_config  = 1'b1;
        @(negedge clock);
        enviar_config  = 1'b0;
        checkOutput("busy_during_tx", 32'(ocupado), 32'd1);
        waitDone(done);
        checkRun(req, done);
        repeat (2 * FRAME_CLKS) @(negedge clock);
        checkOutput("no_second_tx", 32'(frames.size()), 32'd0);
        checkOutput("single_pronto", 32'(pronto_cnt - cnt0), 32'd1);
        checkOutput("idle_tx_serial", 32'(tx_serial), 32'd1);
        checkOutput("idle_ocupado", 32'(ocupado), 32'd0);

        // Reset in the middle of frame 4
        for (int i = 0; i < 5; i++) words[i] = 16'($urandom);
        buildModel(words);
        applyStimulus(words, req);
        waitFrames(3);
        repeat (3 * CPB) @(negedge clock);
        #3 reset = 1'b0;
        #1;
        checkOutput("abort_tx_serial", 32'(tx_serial), 32'd1);
        checkOutput("abort_ocupado", 32'(ocupado), 32'd0);
        checkOutput("abort_estado", 32'(db_estado), 32'd0);
        cnt0 = pronto_cnt;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (FRAME_CLKS + 10) @(negedge clock);
        checkOutput("no_pronto_after_abort", 32'(pronto_cnt - cnt0), 32'd0);
        frames.delete();

        // Restart after abort begins again from the first byte
        words = '{16'h1000, 16'h2001, 16'h3002, 16'h4003, 16'h5004};
        buildModel(words);
        applyStimulus(words, req);
        waitDone(done);
        checkRun(req, done);

        // Random sets, each requested on the clock right after pronto_envio
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 5; i++) words[i] = 16'($urandom);
            buildModel(words);
            applyStimulus(words, req);
            waitDone(done);
            checkRun(req, done);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
